// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX->MEM elastic stage: control bit layout and payload sizing.
package ex_mem_pkg;

  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned CTRL_REG_EN   = 0;
  localparam int unsigned CTRL_MEM_EN   = 1;
  localparam int unsigned CTRL_MEM_WR   = 2;
  localparam int unsigned CTRL_WRT_DMEM = 3;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 3;

  // Payload layout, MSB first: w1_reg, ctrl, writedata, alu_out, r2, halt
  localparam int unsigned PAYLOAD_W = REG_AW_DEF + CTRL_W + 3 * DATA_W_DEF + 1;

  function automatic int unsigned payload_w(input int unsigned data_w,
                                            input int unsigned reg_aw,
                                            input int unsigned ctrl_w);
    return reg_aw + ctrl_w + 3 * data_w + 1;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_pipe_entry.sv
// One payload register of the skid stage: load-enabled flop bank with synchronous clear.
module pipe_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// Elastic EX->MEM stage: head register M plus skid register S, strict FIFO order,
// flush squash, halt tracking and a saturating stall counter.
module ex_mem_skid_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_w1_reg,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_writedata,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_r2,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_w1_reg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_writedata,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_r2,
  output logic              out_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);
  import ex_mem_pkg::*;

  localparam int unsigned PW = payload_w(DATA_W, REG_AW, CTRL_W);

  logic          mv, sv, halt_seen;
  logic          accept, consume, load_m, load_s;
  logic [PW-1:0] in_payload, m_d, m_q, s_q;
  logic [CTRL_W-1:0] m_ctrl;
  logic          m_halt;

  assign in_payload = {in_w1_reg, in_ctrl, in_writedata, in_alu_out, in_r2, in_halt};
  assign {out_w1_reg, m_ctrl, out_writedata, out_alu_out, out_r2, m_halt} = m_q;

  // Handshake: flush blocks both directions combinationally
  assign in_ready  = !sv && !halt_seen && !flush;
  assign out_valid = mv && !flush;
  assign out_ctrl  = out_valid ? m_ctrl : '0;
  assign out_halt  = out_valid && m_halt;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // S refills M first so the skid entry is never overtaken
  assign load_m = (consume && sv) || (accept && (!mv || consume));
  assign load_s = accept && mv && !consume;
  assign m_d    = sv ? s_q : in_payload;

  pipe_entry #(.W(PW)) u_m (
    .clk  (clk),
    .rst  (rst),
    .load (load_m),
    .d    (m_d),
    .q    (m_q)
  );

  pipe_entry #(.W(PW)) u_s (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .d    (in_payload),
    .q    (s_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mv        <= 1'b0;
      sv        <= 1'b0;
      halt_seen <= 1'b0;
    end else if (flush) begin
      mv        <= 1'b0;
      sv        <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      if (consume)     mv <= sv || accept;
      else if (accept) mv <= 1'b1;

      if (consume && sv) sv <= 1'b0;
      else if (load_s)   sv <= 1'b1;

      if (accept && in_halt) halt_seen <= 1'b1;
    end
  end

  // Halt and stall statistics survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (consume && m_halt) halted <= 1'b1;
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: expected entries queued by the driver,
// checked by an independent output monitor.
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [2:0]  w1;
    logic [3:0]  ctrl;
    logic [15:0] wd;
    logic [15:0] alu;
    logic [15:0] r2;
    logic        halt;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_w1_reg;
  logic [3:0]  in_ctrl;
  logic [15:0] in_writedata, in_alu_out, in_r2;
  logic        in_halt, flush;
  logic        out_valid, out_ready;
  logic [2:0]  out_w1_reg;
  logic [3:0]  out_ctrl;
  logic [15:0] out_writedata, out_alu_out, out_r2;
  logic        out_halt, halted;
  logic [3:0]  stall_cnt;

  int tests = 0;
  int fails = 0;
  item_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(16), .REG_AW(3), .CTRL_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_w1_reg    (in_w1_reg),
    .in_ctrl      (in_ctrl),
    .in_writedata (in_writedata),
    .in_alu_out   (in_alu_out),
    .in_r2        (in_r2),
    .in_halt      (in_halt),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_w1_reg   (out_w1_reg),
    .out_ctrl     (out_ctrl),
    .out_writedata(out_writedata),
    .out_alu_out  (out_alu_out),
    .out_r2       (out_r2),
    .out_halt     (out_halt),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  function automatic item_t mk(input logic [15:0] alu, input logic h, input logic [3:0] c);
    item_t it;
    it.w1   = alu[2:0];
    it.ctrl = c;
    it.wd   = alu ^ 16'h5A5A;
    it.r2   = alu + 16'h1000;
    it.alu  = alu;
    it.halt = h;
    return it;
  endfunction

  task automatic drive(input item_t it);
    in_valid     = 1'b1;
    in_w1_reg    = it.w1;
    in_ctrl      = it.ctrl;
    in_writedata = it.wd;
    in_alu_out   = it.alu;
    in_r2        = it.r2;
    in_halt      = it.halt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completed output transfer must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      item_t got, exp;
      got = '{out_w1_reg, out_ctrl, out_writedata, out_alu_out, out_r2, out_halt};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got alu %0h with no entry pending", out_alu_out);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL mon_payload: got %0h expected %0h", got, exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_w1_reg = '0; in_ctrl = '0; in_writedata = '0;
    in_alu_out = '0; in_r2 = '0; in_halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_alu", 32'(out_alu_out), 32'd0);
    rst = 1'b0;
    tick();

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      item_t it;
      it = mk(16'(i), 1'b0, 4'b0001);
      drive(it);
      exp_q.push_back(it);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), (i == 1) ? 32'd0 : 32'd1);
      if (i > 1) chk("stream_latency", 32'(out_alu_out), 32'(i - 1));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'd0);
    chk("stream_stall", 32'(stall_cnt), 32'd0);
    tick();

    // Backpressure: two entries held, third waits at the input
    out_ready = 1'b0;
    exp_q.push_back(mk(16'h00A1, 1'b0, 4'b0011));
    exp_q.push_back(mk(16'h00A2, 1'b0, 4'b0111));
    exp_q.push_back(mk(16'h00A3, 1'b0, 4'b1011));
    drive(mk(16'h00A1, 1'b0, 4'b0011));
    @(negedge clk); chk("bp_rdy_a1", 32'(in_ready), 32'd1); tick();
    drive(mk(16'h00A2, 1'b0, 4'b0111));
    @(negedge clk); chk("bp_rdy_a2", 32'(in_ready), 32'd1); tick();
    drive(mk(16'h00A3, 1'b0, 4'b1011));
    @(negedge clk); chk("bp_full_0", 32'(in_ready), 32'd0); tick();
    @(negedge clk); chk("bp_full_1", 32'(in_ready), 32'd0); tick();
    out_ready = 1'b1;
    @(negedge clk); chk("bp_full_2", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_alu_out), 32'h00A1); tick();
    @(negedge clk); chk("bp_rdy_a3", 32'(in_ready), 32'd1); tick();
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("bp_stall", 32'(stall_cnt), 32'd3);
    chk("bp_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Flush with two entries held
    out_ready = 1'b0;
    drive(mk(16'h00B1, 1'b0, 4'b0001)); tick();
    drive(mk(16'h00B2, 1'b0, 4'b0001)); tick();
    drive(mk(16'h00B3, 1'b0, 4'b0001));
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_out_ctrl", 32'(out_ctrl), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_after_valid", 32'(out_valid), 32'd0);
    chk("fl_after_ready", 32'(in_ready), 32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd4);
    tick();

    // Halt tracking
    out_ready = 1'b0;
    drive(mk(16'h00C1, 1'b1, 4'b0001));
    exp_q.push_back(mk(16'h00C1, 1'b1, 4'b0001));
    @(negedge clk); chk("ht_rdy", 32'(in_ready), 32'd1); tick();
    drive(mk(16'h00C2, 1'b0, 4'b0001));
    @(negedge clk);
    chk("ht_blocked", 32'(in_ready), 32'd0);
    chk("ht_out_halt", 32'(out_halt), 32'd1);
    chk("ht_not_yet", 32'(halted), 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk); chk("ht_blocked2", 32'(in_ready), 32'd0); tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ht_halted", 32'(halted), 32'd1);
    chk("ht_gone", 32'(out_valid), 32'd0);
    chk("ht_still_blocked", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk);
    chk("ht_sticky", 32'(halted), 32'd1);
    chk("ht_flush_unblock", 32'(in_ready), 32'd1);
    tick();

    // Reset while both entries are full
    out_ready = 1'b0;
    drive(mk(16'h00D1, 1'b0, 4'b0101)); tick();
    drive(mk(16'h00D2, 1'b1, 4'b0101)); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_stall", 32'(stall_cnt), 32'd0);
    chk("mr_halted", 32'(halted), 32'd0);
    chk("mr_data", {out_alu_out, out_writedata}, 32'd0);
    chk("mr_misc", {out_r2, 5'd0, out_w1_reg, out_ctrl, 3'd0, out_halt}, 32'd0);
    rst = 1'b0;
    tick();

    // Stall counter saturation
    drive(mk(16'h00E1, 1'b0, 4'b0001));
    exp_q.push_back(mk(16'h00E1, 1'b0, 4'b0001));
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk); chk("sat_mid", 32'(stall_cnt), 32'd5);
    repeat (15) tick();
    @(negedge clk); chk("sat_top", 32'(stall_cnt), 32'hF);
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("sat_hold", 32'(stall_cnt), 32'hF);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
